// File: rtl/nap_pkg.sv
// Shared encodings for the piezo sound arbiter: FSM states, grant bit positions, silence code.
package nap_pkg;

  typedef enum logic [2:0] {
    SA_IDLE  = 3'd0,
    SA_GAP   = 3'd1,
    SA_ALARM = 3'd2,
    SA_CLICK = 3'd3,
    SA_LULL  = 3'd4
  } sa_state_t;

  localparam int GNT_LULL     = 0;
  localparam int GNT_CLICK    = 1;
  localparam int GNT_ALARM    = 2;
  localparam int BEAT_SILENCE = 0;

  function automatic logic [2:0] grant_of(input sa_state_t s);
    logic [2:0] g;
    g = '0;
    case (s)
      SA_ALARM: g[GNT_ALARM] = 1'b1;
      SA_CLICK: g[GNT_CLICK] = 1'b1;
      SA_LULL:  g[GNT_LULL]  = 1'b1;
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sound_timer.sv
// Loadable down-counter that saturates at zero; times both silent gaps and keypad clicks.
// Latency: value/zero reflect a load one clock later.
// Backpressure: none; counts every clock unless reloaded.
module sound_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority, preempting owner select for one piezo: alarm > keypad click > lullaby, silent gap on every change.
// Latency: all outputs registered; beat codes reach play_sound one clock after sampling.
// Backpressure: none; sources are levels, keypad presses beyond one pending click are dropped.
module sound_arbiter
  import nap_pkg::*;
#(
  parameter int                BEAT_W       = 13,
  parameter int                GAP_CYCLES   = 50000,
  parameter int                CLICK_CYCLES = 2500000,
  parameter logic [BEAT_W-1:0] CLICK_CODE   = BEAT_W'(1000)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alarm_req,
  input  logic [BEAT_W-1:0] alarm_beat,
  input  logic              lullaby_req,
  input  logic [BEAT_W-1:0] lullaby_beat,
  input  logic              key_pulse,
  input  logic              mute,
  output logic [BEAT_W-1:0] play_sound,
  output logic [2:0]        grant,
  output logic              busy,
  output logic              preempt
);

  localparam int TMAX = (GAP_CYCLES > CLICK_CYCLES) ? GAP_CYCLES : CLICK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] CLICK_LD = TW'(CLICK_CYCLES - 1);

  sa_state_t         state, next_state, win_state;
  logic              win_vld;
  logic              click_pend, pend_clr, pend_set;
  logic              tmr_load, tmr_zero, pre_nxt;
  logic [TW-1:0]     tmr_val, tmr_value;

  sound_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_comb begin
    win_vld   = 1'b1;
    win_state = SA_IDLE;
    if (alarm_req)        win_state = SA_ALARM;
    else if (click_pend)  win_state = SA_CLICK;
    else if (lullaby_req) win_state = SA_LULL;
    else                  win_vld   = 1'b0;
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = GAP_LD;
    pre_nxt    = 1'b0;
    pend_clr   = 1'b0;
    if (mute) begin
      next_state = SA_IDLE;
      tmr_load   = 1'b1;
      tmr_val    = '0;
      pend_clr   = 1'b1;
    end else begin
      case (state)
        SA_IDLE: begin
          if (win_vld) begin
            next_state = SA_GAP;
            tmr_load   = 1'b1;
          end
        end
        SA_GAP: begin
          // Owner is chosen at the end of the gap, so a late higher request wins.
          if (tmr_zero) begin
            next_state = win_vld ? win_state : SA_IDLE;
            if (win_vld && win_state == SA_CLICK) begin
              tmr_load = 1'b1;
              tmr_val  = CLICK_LD;
            end
          end
        end
        SA_ALARM: begin
          if (!alarm_req) begin
            next_state = SA_GAP;
            tmr_load   = 1'b1;
          end
        end
        SA_CLICK: begin
          if (alarm_req || tmr_zero) begin
            next_state = SA_GAP;
            tmr_load   = 1'b1;
            pend_clr   = 1'b1;
            pre_nxt    = alarm_req;
          end
        end
        SA_LULL: begin
          if (alarm_req || click_pend || !lullaby_req) begin
            next_state = SA_GAP;
            tmr_load   = 1'b1;
            pre_nxt    = alarm_req || click_pend;
          end
        end
        default: begin
          next_state = SA_IDLE;
        end
      endcase
    end
  end

  assign pend_set = key_pulse && !alarm_req && !mute && (state != SA_CLICK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SA_IDLE;
      click_pend <= 1'b0;
      play_sound <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      preempt    <= 1'b0;
    end else begin
      state      <= next_state;
      preempt    <= pre_nxt;
      busy       <= (next_state != SA_IDLE);
      grant      <= grant_of(next_state);
      if (pend_clr)      click_pend <= 1'b0;
      else if (pend_set) click_pend <= 1'b1;
      case (next_state)
        SA_ALARM: play_sound <= alarm_beat;
        SA_CLICK: play_sound <= CLICK_CODE;
        SA_LULL:  play_sound <= lullaby_beat;
        default:  play_sound <= BEAT_W'(BEAT_SILENCE);
      endcase
    end
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboarded random/directed bench for sound_arbiter against a priority/countdown reference model.
module tb_sound_arbiter;

  localparam int GAP_N   = 4;
  localparam int CLICK_N = 8;
  localparam int M_IDLE  = 0;
  localparam int M_GAP   = 1;
  localparam int M_PLAY  = 2;

  typedef struct packed {
    logic [12:0] play;
    logic [2:0]  grant;
    logic        busy;
    logic        pre;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alarm_req = 1'b0, lullaby_req = 1'b0, key_pulse = 1'b0, mute = 1'b0;
  logic [12:0] alarm_beat = '0, lullaby_beat = '0;
  logic [12:0] play_sound;
  logic [2:0]  grant;
  logic        busy, preempt;

  int n_checks = 0;
  int n_errors = 0;
  int n_push   = 0;
  int n_pop    = 0;
  exp_t sb_q[$];

  int m_mode = M_IDLE;
  int m_src  = 0;
  int m_cnt  = 0;
  bit m_pend = 1'b0;

  sound_arbiter #(
    .BEAT_W       (13),
    .GAP_CYCLES   (GAP_N),
    .CLICK_CYCLES (CLICK_N),
    .CLICK_CODE   (13'd1000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .alarm_req    (alarm_req),
    .alarm_beat   (alarm_beat),
    .lullaby_req  (lullaby_req),
    .lullaby_beat (lullaby_beat),
    .key_pulse    (key_pulse),
    .mute         (mute),
    .play_sound   (play_sound),
    .grant        (grant),
    .busy         (busy),
    .preempt      (preempt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Reference: priority ranks 3=alarm 2=click 1=lullaby; counters hold clocks remaining.
  task automatic model_step();
    int   w;
    bit   pre, clr, set_ok;
    exp_t e;
    w      = alarm_req ? 3 : m_pend ? 2 : lullaby_req ? 1 : 0;
    pre    = 1'b0;
    clr    = 1'b0;
    set_ok = key_pulse && !alarm_req && !mute && !(m_mode == M_PLAY && m_src == 2);
    if (mute) begin
      m_mode = M_IDLE;
      clr    = 1'b1;
    end else if (m_mode == M_IDLE) begin
      if (w != 0) begin m_mode = M_GAP; m_cnt = GAP_N; end
    end else if (m_mode == M_GAP) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (w == 0) m_mode = M_IDLE;
        else begin m_mode = M_PLAY; m_src = w; m_cnt = CLICK_N; end
      end
    end else begin
      if (w > m_src) begin
        pre = 1'b1; clr = (m_src == 2); m_mode = M_GAP; m_cnt = GAP_N;
      end else if (m_src == 2) begin
        m_cnt--;
        if (m_cnt == 0) begin clr = 1'b1; m_mode = M_GAP; m_cnt = GAP_N; end
      end else if (w < m_src) begin
        m_mode = M_GAP; m_cnt = GAP_N;
      end
    end
    if (clr) m_pend = 1'b0;
    else if (set_ok) m_pend = 1'b1;
    e.pre   = pre;
    e.busy  = (m_mode != M_IDLE);
    e.grant = (m_mode == M_PLAY) ? 3'(1 << (m_src - 1)) : 3'b000;
    e.play  = (m_mode != M_PLAY) ? 13'd0 :
              (m_src == 3) ? alarm_beat : (m_src == 2) ? 13'd1000 : lullaby_beat;
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic cyc(input bit a, input logic [12:0] ab, input bit l, input logic [12:0] lb,
                     input bit k, input bit m);
    @(negedge clock);
    alarm_req = a; alarm_beat = ab; lullaby_req = l; lullaby_beat = lb;
    key_pulse = k; mute = m;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_pop++;
      n_checks++;
      if ({play_sound, grant, busy, preempt} !== e) begin
        n_errors++;
        $display("FAIL out@%0t: got play=%0d grant=%b busy=%b pre=%b, want play=%0d grant=%b busy=%b pre=%b",
                 $time, play_sound, grant, busy, preempt, e.play, e.grant, e.busy, e.pre);
      end
    end
  end

  initial begin
    bit          a, l, k, m;
    logic [12:0] ab, lb;
    #3;
    chk("rst_play", int'(play_sound), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pre", int'(preempt), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 523, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 880, 1, 523, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 523, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(6);

    cyc(0, 0, 0, 0, 1, 0);
    idle(8);
    cyc(0, 0, 0, 0, 1, 0);
    idle(16);

    cyc(1, 880, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 880, 0, 0, i == 5, 0);
    idle(12);

    for (int i = 0; i < 8; i++) cyc(1, 440, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 440, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 440, 0, 0, 0, 0);
    idle(6);

    cyc(0, 0, 1, 300, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 300, 0, 0);
    idle(6);

    cyc(0, 0, 0, 0, 1, 0);
    idle(9);
    @(posedge clock);
    #2;
    chk("click_tone", int'(play_sound), 1000);
    chk("click_grant", int'(grant), 3'b010);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_play", int'(play_sound), 0);
    chk("arst_grant", int'(grant), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pre", int'(preempt), 0);
    m_mode = M_IDLE; m_cnt = 0; m_pend = 1'b0; m_src = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    idle(8);

    a = 0; l = 0; m = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) a = !a;
      if ($urandom_range(0, 14) == 0) l = !l;
      if (m) m = ($urandom_range(0, 3) != 0);
      else   m = ($urandom_range(0, 299) == 0);
      k  = ($urandom_range(0, 24) == 0);
      ab = ($urandom_range(0, 7) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
      lb = ($urandom_range(0, 7) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
      cyc(a, ab, l, lb, k, m);
    end
    idle(4);
    @(posedge clock);
    #3;
    chk("sb_drained", n_pop, n_push);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
